// File: rtl/phase_gen_pkg.sv
// rtl/phase_gen_pkg.sv - shared Q3.13 phase constants and FSM state encoding
package phase_gen_pkg;

    localparam int PI_POS = 25736;
    localparam int PI_NEG = -25736;
    localparam int TWO_PI = 51472;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/phase_wrap_acc.sv
// rtl/phase_wrap_acc.sv - registered Q3.13 phase accumulator wrapping into [-pi, pi)
module phase_wrap_acc
    import phase_gen_pkg::*;
#(
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               adv_i,
    input  logic [PHASE_W-1:0] inc_i,
    output logic [PHASE_W-1:0] phase_o
);

    localparam logic signed [PHASE_W+1:0] PI_POS_X = (PHASE_W+2)'(PI_POS);
    localparam logic signed [PHASE_W+1:0] TWO_PI_X = (PHASE_W+2)'(TWO_PI);

    logic [PHASE_W-1:0]        phase_q, phase_d;
    logic signed [PHASE_W+1:0] sum;
    logic [PHASE_W-1:0]        wrapped;

    // Two guard bits keep phase + inc exact before the single wrap subtraction.
    always_comb begin
        sum     = {{2{phase_q[PHASE_W-1]}}, phase_q} + {2'b00, inc_i};
        wrapped = PHASE_W'((sum >= PI_POS_X) ? (sum - TWO_PI_X) : sum);
        phase_d = phase_q;
        if (load_i) begin
            phase_d = '0;
        end else if (adv_i) begin
            phase_d = wrapped;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/phase_sweep_gen.sv
// rtl/phase_sweep_gen.sv - tone/chirp phase stream source; PHASE_GEN_TLAST_EN adds m_axis_phase_tlast
module phase_sweep_gen
    import phase_gen_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               cfg_sweep,
    input  logic [PHASE_W-1:0] cfg_inc_start,
    input  logic [PHASE_W-1:0] cfg_inc_stop,
    input  logic [PHASE_W-1:0] cfg_inc_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               sweep_done,
    output logic               m_axis_phase_tvalid,
    input  logic               m_axis_phase_tready,
    output logic [PHASE_W-1:0] m_axis_phase_tdata
`ifdef PHASE_GEN_TLAST_EN
    ,
    output logic               m_axis_phase_tlast
`endif
);

    localparam logic [PHASE_W-1:0] INC_MAX = PHASE_W'(PI_POS - 1);

    function automatic logic [PHASE_W-1:0] clamp_inc(input logic [PHASE_W-1:0] v);
        return (v > INC_MAX) ? INC_MAX : v;
    endfunction

    state_e             state_q, state_d;
    logic               sweep_q;
    logic [PHASE_W-1:0] inc_start_q, inc_stop_q, inc_step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [PHASE_W-1:0] cur_inc_q, cur_inc_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               acc_load, acc_adv;
    logic               xfer, sweep_act, dwell_last, last_final;
    logic [DWELL_W-1:0] dwell_eff;
    logic [PHASE_W:0]   inc_sum;
    logic [PHASE_W-1:0] inc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_q     <= 1'b0;
            inc_start_q <= '0;
            inc_stop_q  <= '0;
            inc_step_q  <= '0;
            dwell_q     <= '0;
        end else if (cfg_valid && cfg_ready) begin
            sweep_q     <= cfg_sweep;
            inc_start_q <= clamp_inc(cfg_inc_start);
            inc_stop_q  <= clamp_inc(cfg_inc_stop);
            inc_step_q  <= clamp_inc(cfg_inc_step);
            dwell_q     <= cfg_dwell;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_inc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_inc_q <= cur_inc_d;
            cnt_q     <= cnt_d;
        end
    end

    // A degenerate sweep (zero step or start >= stop) runs as a plain tone.
    always_comb begin
        xfer       = m_axis_phase_tvalid & m_axis_phase_tready;
        sweep_act  = sweep_q && (inc_step_q != '0) && (inc_start_q < inc_stop_q);
        dwell_eff  = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
        dwell_last = (cnt_q == (dwell_eff - DWELL_W'(1)));
        last_final = (state_q == RUN) && sweep_act && dwell_last && (cur_inc_q == inc_stop_q);
        inc_sum    = {1'b0, cur_inc_q} + {1'b0, inc_step_q};
        inc_next   = (inc_sum >= {1'b0, inc_stop_q}) ? inc_stop_q : inc_sum[PHASE_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cur_inc_d = cur_inc_q;
        cnt_d     = cnt_q;
        acc_load  = 1'b0;
        acc_adv   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d   = RUN;
                    acc_load  = 1'b1;
                    cur_inc_d = inc_start_q;
                    cnt_d     = '0;
                end
            end
            RUN: begin
                if (xfer) begin
                    acc_adv = 1'b1;
                    if (dwell_last) begin
                        cnt_d = '0;
                        if (sweep_act) begin
                            cur_inc_d = inc_next;
                        end
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end
                if (stop && !m_axis_phase_tready) begin
                    state_d = DRAIN;
                end else if (stop || (last_final && xfer)) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    phase_wrap_acc #(
        .PHASE_W(PHASE_W)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .load_i (acc_load),
        .adv_i  (acc_adv),
        .inc_i  (cur_inc_q),
        .phase_o(m_axis_phase_tdata)
    );

    assign cfg_ready           = (state_q == IDLE);
    assign busy                = (state_q != IDLE);
    assign m_axis_phase_tvalid = (state_q != IDLE);
    assign sweep_done          = last_final & xfer;

`ifdef PHASE_GEN_TLAST_EN
    assign m_axis_phase_tlast = last_final | (state_q == DRAIN);
`endif

endmodule

// File: tb/tb_phase_sweep_gen.sv
// tb/tb_phase_sweep_gen.sv - randomized bench for phase_sweep_gen against a beat-indexed reference model
module tb_phase_sweep_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready, cfg_sweep;
    logic [15:0] cfg_inc_start, cfg_inc_stop, cfg_inc_step, cfg_dwell;
    logic        start, stop, busy, sweep_done;
    logic        tvalid, tready;
    logic [15:0] tdata;
`ifdef PHASE_GEN_TLAST_EN
    logic        tlast;
`endif

    always #5 clk = ~clk;

    phase_sweep_gen #(.PHASE_W(16), .DWELL_W(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .cfg_sweep          (cfg_sweep),
        .cfg_inc_start      (cfg_inc_start),
        .cfg_inc_stop       (cfg_inc_stop),
        .cfg_inc_step       (cfg_inc_step),
        .cfg_dwell          (cfg_dwell),
        .start              (start),
        .stop               (stop),
        .busy               (busy),
        .sweep_done         (sweep_done),
        .m_axis_phase_tvalid(tvalid),
        .m_axis_phase_tready(tready),
        .m_axis_phase_tdata (tdata)
`ifdef PHASE_GEN_TLAST_EN
        ,
        .m_axis_phase_tlast (tlast)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: phase is a function of the beat index and the configured schedule.
    bit  m_valid = 0, m_drain = 0;
    int  m_phase = 0, m_beat = 0;
    bit  c_sweep = 0;
    int  c_start = 0, c_stop = 0, c_step = 0, c_dwell = 0;
    int  xlog[$];
    int  xfer_cnt = 0, done_cnt = 0, done_idx = -1;
    bit  rdy_rand = 0;

    function automatic int clampv(input int v);
        return (v >= 25736) ? 25735 : v;
    endfunction
    function automatic int wrapv(input int s);
        return (s >= 25736) ? s - 51472 : s;
    endfunction
    function automatic bit act();
        return c_sweep && c_step != 0 && c_start < c_stop;
    endfunction
    function automatic int deff();
        return (c_dwell == 0) ? 1 : c_dwell;
    endfunction
    function automatic int total();
        return deff() * ((c_stop - c_start + c_step - 1) / c_step + 1);
    endfunction
    function automatic int inc_for(input int n);
        int v;
        if (!act()) return c_start;
        v = c_start + c_step * (n / deff());
        return (v > c_stop) ? c_stop : v;
    endfunction
    function automatic int logv(input int i);
        return (i < xlog.size()) ? xlog[i] : -99999;
    endfunction

    initial begin
        bit fin, exp_done;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_tvalid", longint'(tvalid), 0);
                chk("rst_busy", longint'(busy), 0);
                chk("rst_tdata", longint'(tdata), 0);
                m_valid = 0; m_drain = 0;
                c_sweep = 0; c_start = 0; c_stop = 0; c_step = 0; c_dwell = 0;
                continue;
            end
            exp_done = m_valid && !m_drain && act() && (m_beat == total() - 1) && tready;
            chk("tvalid", longint'(tvalid), longint'(m_valid));
            chk("busy", longint'(busy), longint'(m_valid));
            chk("cfg_ready", longint'(cfg_ready), longint'(!m_valid));
            chk("sweep_done", longint'(sweep_done), longint'(exp_done));
            if (m_valid) chk("tdata", longint'($signed(tdata)), m_phase);
`ifdef PHASE_GEN_TLAST_EN
            chk("tlast", longint'(tlast),
                longint'(m_valid && (m_drain || (act() && m_beat == total() - 1))));
`endif
            if (tvalid && tready) begin
                xlog.push_back(int'($signed(tdata)));
                xfer_cnt++;
            end
            if (sweep_done) begin
                done_cnt++;
                done_idx = xfer_cnt - 1;
            end
            if (!m_valid) begin
                if (start && !stop) begin
                    m_valid = 1; m_phase = 0; m_beat = 0;
                end else if (cfg_valid) begin
                    c_sweep = cfg_sweep;
                    c_start = clampv(int'(cfg_inc_start));
                    c_stop  = clampv(int'(cfg_inc_stop));
                    c_step  = clampv(int'(cfg_inc_step));
                    c_dwell = int'(cfg_dwell);
                end
            end else if (m_drain) begin
                if (tready) begin m_valid = 0; m_drain = 0; end
            end else begin
                fin = act() && (m_beat == total() - 1) && tready;
                if (tready) begin
                    m_phase = wrapv(m_phase + inc_for(m_beat));
                    m_beat++;
                end
                if (stop && !tready) m_drain = 1;
                else if (stop || fin) m_valid = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rdy_rand) tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic cfg(input bit sw, input int st, input int sp, input int stp, input int dw);
        cfg_sweep = sw;
        cfg_inc_start = 16'(st); cfg_inc_stop = 16'(sp);
        cfg_inc_step = 16'(stp); cfg_dwell = 16'(dw);
        cfg_valid = 1; cyc(1); cfg_valid = 0;
    endtask

    task automatic go();
        xlog.delete(); xfer_cnt = 0; done_cnt = 0; done_idx = -1;
        start = 1; cyc(1); start = 0;
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int k = 0;
        while (xfer_cnt < n && k < budget) begin cyc(1); k++; end
        chk("timeout_xfers", longint'(xfer_cnt >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin cyc(1); k++; end
        chk("timeout_idle", longint'(busy), 0);
    endtask

    task automatic halt();
        stop = 1; cyc(1); stop = 0;
        rdy_rand = 0; tready = 1;
        wait_idle(50);
    endtask

    initial begin
        int bad, n0;
        int exp4[12] = '{0, 200, 400, 600, 800, 1200, 1600, 2000, 2400, 3000, 3600, 4200};
        rst = 1; cfg_valid = 0; cfg_sweep = 0; cfg_inc_start = 0; cfg_inc_stop = 0;
        cfg_inc_step = 0; cfg_dwell = 0; start = 0; stop = 0; tready = 1;
        cyc(3); rst = 0; cyc(1);
        chk("reset_tvalid", longint'(tvalid), 0);
        chk("reset_tdata", longint'(tdata), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(sweep_done), 0);
        chk("reset_cfg_ready", longint'(cfg_ready), 1);

        // Tone 200: wrap at beat 129
        cfg(0, 200, 0, 0, 1); go(); wait_xfers(130, 200);
        chk("t1_b0", logv(0), 0);
        chk("t1_b1", logv(1), 200);
        chk("t1_b128", logv(128), 25600);
        chk("t1_b129", logv(129), -25672);
        halt();
        chk("t1_no_done", done_cnt, 0);

        // Tone 3000 over 10k beats, range bound
        cfg(0, 3000, 0, 0, 1); go(); wait_xfers(10000, 10100);
        chk("t2_b8", logv(8), 24000);
        chk("t2_b9", logv(9), -24472);
        bad = 0;
        foreach (xlog[i]) if (xlog[i] < -25736 || xlog[i] > 25735) bad++;
        chk("t2_range", bad, 0);
        halt();

        // Backpressure, ignored mid-run config, random ready
        cfg(0, 777, 0, 0, 1); go(); wait_xfers(20, 40);
        tready = 0; cyc(5); tready = 1;
        cfg(0, 999, 0, 0, 1);
        rdy_rand = 1; wait_xfers(300, 1500);
        rdy_rand = 0; tready = 1; cyc(1);
        bad = 0;
        for (int i = 0; i + 1 < xlog.size(); i++) if (wrapv(xlog[i] + 777) != xlog[i + 1]) bad++;
        chk("t3_seq", bad, 0);
        halt();

        // Sweep 200..600 step 200 dwell 4
        cfg(1, 200, 600, 200, 4); go(); wait_idle(100);
        chk("t4_len", xlog.size(), 12);
        for (int i = 0; i < 12; i++) chk("t4_phase", logv(i), exp4[i]);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_done_idx", done_idx, 11);

        // Random sweeps under random backpressure
        for (int it = 0; it < 6; it++) begin
            int st, stp, sp, dw;
            st = int'($urandom_range(0, 2000)); stp = int'($urandom_range(50, 800));
            sp = st + int'($urandom_range(1, 2000)); dw = int'($urandom_range(0, 5));
            cfg(1, st, sp, stp, dw); rdy_rand = 1; go(); wait_idle(3000);
            rdy_rand = 0; tready = 1;
            chk("rsw_done", done_cnt, 1);
        end

        // Degenerate sweeps behave as tone
        cfg(1, 500, 300, 100, 2); rdy_rand = 1; go(); wait_xfers(60, 400); halt();
        chk("deg1_no_done", done_cnt, 0);
        cfg(1, 100, 900, 0, 1); rdy_rand = 1; go(); wait_xfers(60, 400); halt();
        chk("deg2_no_done", done_cnt, 0);

        // Stop under backpressure -> DRAIN, exactly one more beat
        cfg(0, 100, 0, 0, 1); go(); wait_xfers(10, 30);
        tready = 0; stop = 1; cyc(1); stop = 0; cyc(3);
        chk("t5_held_valid", longint'(tvalid), 1);
        chk("t5_held_busy", longint'(busy), 1);
        n0 = xfer_cnt;
        tready = 1; cyc(1);
        chk("t5_idle", longint'(busy), 0);
        cyc(2);
        chk("t5_one_beat", xfer_cnt - n0, 1);

        // Start and stop together in IDLE
        start = 1; stop = 1; cyc(1); start = 0; stop = 0; cyc(1);
        chk("start_stop_idle", longint'(busy), 0);

        // Clamp, then async reset mid-run and restart
        cfg(0, 16'h7000, 0, 0, 1); go(); wait_xfers(3, 10);
        chk("t6_clamp_b1", logv(1), 25735);
        chk("t6_clamp_b2", logv(2), -2);
        rst = 1; #1;
        chk("t6_async_tvalid", longint'(tvalid), 0);
        chk("t6_async_busy", longint'(busy), 0);
        cyc(2); rst = 0; cyc(1);
        cfg(0, 50, 0, 0, 1); go(); wait_xfers(2, 10);
        chk("t6_restart_b0", logv(0), 0);
        chk("t6_restart_b1", logv(1), 50);
        halt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phase_sweep_gen.md
Name: phase_sweep_gen

Overview:
Upstream stage for the cordic_0 sine/cosine generator. Produces a wrapped radian phase stream in signed Q3.13 on an AXI4-Stream master port. Supports a fixed-tone mode and a linear frequency-sweep (chirp) mode. Replaces hand-written phase ramps and drives the CORDIC → FIR signal path with programmable test tones.

Parameters:
PHASE_W, 16, phase and increment width (Q3.13 radians)
DWELL_W, 16, width of dwell counter (beats per sweep step)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  config write strobe
cfg_ready  out  1  high only in IDLE
cfg_sweep  in  1  0 = tone, 1 = sweep
cfg_inc_start  in  PHASE_W  tone increment / sweep start increment (unsigned)
cfg_inc_stop  in  PHASE_W  sweep final increment (unsigned)
cfg_inc_step  in  PHASE_W  sweep increment delta (unsigned)
cfg_dwell  in  DWELL_W  accepted beats per increment value (0 treated as 1)
start  in  1  begin generation (IDLE only)
stop  in  1  abort generation
busy  out  1  state != IDLE
sweep_done  out  1  one-cycle pulse at sweep completion
m_axis_phase_tvalid  out  1  phase valid
m_axis_phase_tready  in  1  downstream ready
m_axis_phase_tdata  out  PHASE_W  signed Q3.13 phase in [PI_NEG, PI_POS)

Behaviour:
- Reset (async, rst=1): state IDLE; tvalid=0, tdata=0, busy=0, sweep_done=0, cfg_ready=1; config registers cleared.
- Constants: PI_POS=16'h6488 (25736), PI_NEG=16'h9B78 (-25736), TWO_PI=51472.
- Config captured on cfg_valid&cfg_ready. Any increment ≥ PI_POS is clamped to PI_POS-1. cfg_valid outside IDLE is ignored.
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on start. Accumulator is set to 0 and cur_inc to inc_start. tvalid rises the next cycle with tdata=0.
  - RUN→DRAIN on stop while tvalid&!tready.
  - RUN→IDLE on stop when no beat is pending, or when the sweep completes.
  - DRAIN→IDLE on the next transfer. AXI rule: tvalid never drops before a handshake.
- Transfer = tvalid&tready. The phase advances only on a transfer. tdata and tvalid are held stable under backpressure.
- Wrap arithmetic, computed in PHASE_W+2 bits: sum = phase + cur_inc. If sum ≥ PI_POS, next = sum − TWO_PI; otherwise next = sum. The result always lies in [PI_NEG, PI_POS).
- Tone mode: cur_inc is constant. Runs until stop.
- Sweep mode:
  - Dwell counter counts transfers.
  - After cfg_dwell transfers at the current increment: if cur_inc == inc_stop, pulse sweep_done with the last transfer and go to IDLE. Otherwise cur_inc = min(cur_inc + inc_step, inc_stop) and the counter restarts.
  - inc_step == 0, or inc_start ≥ inc_stop, behaves as tone mode and never asserts sweep_done.
- Simultaneous start and stop in IDLE: stop wins; remain in IDLE.
- Simultaneous stop and sweep completion: one transition to IDLE, sweep_done still pulses.
- Throughput: one beat per cycle with tready held high.

Optional Feature:
Macro PHASE_GEN_TLAST_EN.
- Defined: adds output port m_axis_phase_tlast. It is high on the final beat of a completed sweep and on the beat transferred in DRAIN; 0 otherwise and at reset.
- Undefined: the port is absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include phase_gen_pkg:
  - constants PI_POS, PI_NEG, TWO_PI
  - state encodings IDLE=2'd0, RUN=2'd1, DRAIN=2'd2
- Sub-module phase_wrap_acc: registered accumulator with load, advance enable and wrap.
- phase_sweep_gen contains the FSM, config registers, dwell counter and AXI output.

Test Plan:
1. Tone inc=200, tready=1, start → tdata 0, 200, 400, …; beat 128 = 25600; beat 129 = −25672; no sweep_done.
2. Tone inc=3000 → 0, 3000, …, 24000, then −24472; every output stays within [−25736, 25735] over 10k beats.
3. Backpressure: tready=0 for 5 cycles mid-stream → tvalid stays 1 and tdata is frozen; the sequence resumes with no skipped or duplicated phase.
4. Sweep start=200, step=200, stop=600, dwell=4 → phases 0, 200, 400, 600, 800 (4 beats @200), 1200, …, (4 @400), then 4 @600. sweep_done pulses on the 12th transfer; busy=0 on the next cycle.
5. stop while tready=0 → state DRAIN, tvalid held; one transfer, then IDLE and tvalid=0 (tlast=1 on that beat if PHASE_GEN_TLAST_EN).
6. cfg_inc_start=16'h7000 → clamped to 25735. rst asserted mid-RUN → tvalid=0 and busy=0 asynchronously; after release, restart yields tdata=0 first.
